// File: rtl/frame_pkg.sv
// Shared frame buffer constants and the painter FSM state type.
// Imported by frame_painter (write side) and frame_displayer (read side).
package frame_pkg;

  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned FB_PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } painter_state_t;

endpackage

// File: rtl/painter_addr_gen.sv
// Raster-order address generator for rectangle fills.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture x0/y0 (start corner) and x_end/y_end (exclusive bounds)
//   step       : advance to the next pixel in row-major order
//   addr       : registered frame buffer address (row_base + x) of the current pixel
//   last       : current pixel is the final one of the region
module painter_addr_gen #(
  parameter int unsigned H_RES  = frame_pkg::H_RES,
  parameter int unsigned ADDR_W = frame_pkg::FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [9:0]        x0,
  input  logic [9:0]        y0,
  input  logic [10:0]       x_end,
  input  logic [10:0]       y_end,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [9:0]        x_q, y_q, x0_q;
  logic [10:0]       x_end_q, y_end_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] y0_w, row_base_load, next_row;
  logic              row_end;

  // y0 * 640 built from shifts: 640 = 512 + 128
  assign y0_w          = ADDR_W'(y0);
  assign row_base_load = (y0_w << 9) + (y0_w << 7);
  assign next_row      = row_base_q + ADDR_W'(H_RES);

  assign row_end = (({1'b0, x_q} + 11'd1) == x_end_q);
  assign last    = row_end && (({1'b0, y_q} + 11'd1) == y_end_q);

  // addr is kept as its own register (incremented along a row, rebuilt
  // from the next row base at row wrap) so the write address leaves as a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      x0_q       <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      addr       <= '0;
    end else if (load) begin
      x_q        <= x0;
      y_q        <= y0;
      x0_q       <= x0;
      x_end_q    <= x_end;
      y_end_q    <= y_end;
      row_base_q <= row_base_load;
      addr       <= row_base_load + ADDR_W'(x0);
    end else if (step) begin
      if (row_end) begin
        x_q        <= x0_q;
        y_q        <= y_q + 10'd1;
        row_base_q <= next_row;
        addr       <= next_row + ADDR_W'(x0_q);
      end else begin
        x_q  <= x_q + 10'd1;
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_painter.sv
// Write-side engine for the frame buffer: fills one clipped rectangle (or the
// whole screen) per command, one pixel per clock in row-major order.
//   Clk, Reset          : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, accepted when both high
//   cmd_x/y/w/h         : rectangle corner and size in pixels
//   cmd_color           : fill colour
//   cmd_clear           : fill the whole screen, coordinates ignored
//   wr_addr/data/en     : registered frame buffer write port
//   busy                : command in progress
//   done                : one-cycle pulse on command completion
module frame_painter #(
  parameter int unsigned H_RES  = frame_pkg::H_RES,
  parameter int unsigned V_RES  = frame_pkg::V_RES,
  parameter int unsigned ADDR_W = frame_pkg::FB_ADDR_W,
  parameter int unsigned PIX_W  = frame_pkg::FB_PIX_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [PIX_W-1:0]  cmd_color,
  input  logic              cmd_clear,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);
  import frame_pkg::*;

  painter_state_t   state_q, state_d;
  logic [9:0]       x_q, y_q, w_q, h_q;
  logic [PIX_W-1:0] color_q;
  logic             clear_q;
  logic             accept, load, step, last, empty;
  logic [10:0]      x_sum, y_sum, x_end, y_end;
  logic [9:0]       x0, y0;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Clipped bounds from the latched command; 11-bit sums cannot wrap.
  always_comb begin
    x_sum = {1'b0, x_q} + {1'b0, w_q};
    y_sum = {1'b0, y_q} + {1'b0, h_q};
    x0    = x_q;
    y0    = y_q;
    x_end = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
    y_end = (y_sum > 11'(V_RES)) ? 11'(V_RES) : y_sum;
    empty = ({1'b0, x_q} >= 11'(H_RES)) || ({1'b0, y_q} >= 11'(V_RES)) ||
            (w_q == '0) || (h_q == '0);
    if (clear_q) begin
      x0    = '0;
      y0    = '0;
      x_end = 11'(H_RES);
      y_end = 11'(V_RES);
      empty = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE:  if (cmd_valid) state_d = SETUP;
      SETUP: begin
        load    = 1'b1;
        state_d = empty ? DONE : FILL;
      end
      FILL: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // wr_en/done are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      wr_en   <= 1'b0;
      wr_data <= '0;
      done    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en   <= (state_d == FILL);
      done    <= (state_d == DONE);
      if (state_q == SETUP) wr_data <= color_q;
      if (accept) begin
        x_q     <= cmd_x;
        y_q     <= cmd_y;
        w_q     <= cmd_w;
        h_q     <= cmd_h;
        color_q <= cmd_color;
        clear_q <= cmd_clear;
      end
    end
  end

  painter_addr_gen #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (Clk),
    .reset  (Reset),
    .load   (load),
    .x0     (x0),
    .y0     (y0),
    .x_end  (x_end),
    .y_end  (y_end),
    .step   (step),
    .addr   (wr_addr),
    .last   (last)
  );

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter. A second instance with a reduced
// V_RES exercises the full-screen clear in a short run.
module tb_frame_painter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0, s_cmd_valid = 1'b0;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        cmd_clear = 1'b0;

  logic        cmd_ready, wr_en, busy, done;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        s_cmd_ready, s_wr_en, s_busy, s_done;
  logic [18:0] s_wr_addr;
  logic [7:0]  s_wr_data;

  always #5 Clk = ~Clk;

  frame_painter #(.H_RES(640), .V_RES(480), .ADDR_W(19), .PIX_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_clear(cmd_clear),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
  );

  frame_painter #(.H_RES(640), .V_RES(32), .ADDR_W(19), .PIX_W(8)) dut_small (
    .Clk(Clk), .Reset(Reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_clear(cmd_clear),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_en(s_wr_en), .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int passed = 0;
  logic [18:0] q_addr[$];
  logic [7:0]  q_data[$];
  int first_off, last_off, done_off;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a command on the main DUT; returns at #1 into cycle N+1.
  task automatic issue(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                       input logic [9:0] h, input logic [7:0] c, input logic clr);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c; cmd_clear = clr;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Record writes of the main DUT from cycle N+1 until done or budget expiry.
  task automatic collect(input int budget);
    int off;
    off = 1;
    q_addr.delete(); q_data.delete();
    first_off = -1; last_off = -1; done_off = -1;
    while (off <= budget) begin
      if (wr_en) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        if (first_off < 0) first_off = off;
        last_off = off;
      end
      if (done) begin
        done_off = off;
        break;
      end
      tick();
      off++;
    end
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd_x = 10'd3; cmd_w = 10'd3; cmd_h = 10'd3;
    Reset = 1'b1;
    tick(); tick();
    checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b expected 0", wr_en); else passed++;
    checks++; if (wr_addr !== 19'd0) $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); else passed++;
    checks++; if (wr_data !== 8'd0) $display("FAIL reset_wr_data: got %0h expected 0", wr_data); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); else passed++;
    cmd_valid = 1'b0;
    Reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %0b expected 0", busy); else passed++;
  endtask

  task automatic test_rect();
    logic [18:0] exp_a;
    issue(10'd10, 10'd20, 10'd4, 10'd2, 8'h5A, 1'b0);
    checks++; if ({busy, cmd_ready, wr_en} !== 3'b100) $display("FAIL rect_setup_flags: got %b expected 100", {busy, cmd_ready, wr_en}); else passed++;
    collect(50);
    checks++; if (q_addr.size() !== 8) $display("FAIL rect_count: got %0d expected 8", q_addr.size()); else passed++;
    checks++; if (first_off !== 2 || last_off !== 9) $display("FAIL rect_window: got %0d..%0d expected 2..9", first_off, last_off); else passed++;
    checks++; if (done_off !== 10) $display("FAIL rect_done_off: got %0d expected 10", done_off); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp_a = (i < 4) ? 19'(12810 + i) : 19'(13450 + i - 4);
      checks++;
      if (i >= q_addr.size() || {q_addr[i], q_data[i]} !== {exp_a, 8'h5A})
        $display("FAIL rect_pixel%0d: got addr %0d data %0h expected addr %0d data 5a", i,
                 (i < q_addr.size()) ? q_addr[i] : 19'h7FFFF, (i < q_data.size()) ? q_data[i] : 8'hXX, exp_a);
      else passed++;
    end
    tick();
    checks++; if ({cmd_ready, done} !== 2'b10) $display("FAIL rect_ready_after: got %b expected 10", {cmd_ready, done}); else passed++;
  endtask

  task automatic test_clip();
    issue(10'd638, 10'd479, 10'd5, 10'd5, 8'hC3, 1'b0);
    collect(50);
    checks++; if (q_addr.size() !== 2) $display("FAIL clip_count: got %0d expected 2", q_addr.size()); else passed++;
    checks++;
    if (q_addr.size() < 2 || {q_addr[0], q_addr[1], q_data[0], q_data[1]} !== {19'd307198, 19'd307199, 8'hC3, 8'hC3})
      $display("FAIL clip_pixels: got %0d writes expected 307198,307199 colour c3", q_addr.size());
    else passed++;
    checks++; if (done_off !== 4) $display("FAIL clip_done_off: got %0d expected 4", done_off); else passed++;
    tick();
  endtask

  task automatic test_empty();
    issue(10'd100, 10'd100, 10'd0, 10'd7, 8'hFF, 1'b0);
    collect(20);
    checks++; if (q_addr.size() !== 0) $display("FAIL empty_w0_writes: got %0d expected 0", q_addr.size()); else passed++;
    checks++; if (done_off !== 2) $display("FAIL empty_w0_done_off: got %0d expected 2", done_off); else passed++;
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL empty_w0_ready: got %0b expected 1", cmd_ready); else passed++;
    issue(10'd640, 10'd0, 10'd5, 10'd5, 8'hFF, 1'b0);
    collect(20);
    checks++; if (q_addr.size() !== 0) $display("FAIL empty_x640_writes: got %0d expected 0", q_addr.size()); else passed++;
    checks++; if (done_off !== 2) $display("FAIL empty_x640_done_off: got %0d expected 2", done_off); else passed++;
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL empty_x640_ready: got %0b expected 1", cmd_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    issue(10'd0, 10'd0, 10'd3, 10'd1, 8'h11, 1'b0);
    // second command queued with valid held, fields changed under the first
    cmd_x = 10'd5; cmd_y = 10'd1; cmd_w = 10'd2; cmd_h = 10'd1; cmd_color = 8'h22;
    cmd_valid = 1'b1;
    collect(50);
    checks++;
    if (q_addr.size() != 3 || {q_addr[0], q_addr[1], q_addr[2]} !== {19'd0, 19'd1, 19'd2} ||
        {q_data[0], q_data[1], q_data[2]} !== {8'h11, 8'h11, 8'h11})
      $display("FAIL b2b_first_pixels: got %0d writes expected addr 0,1,2 colour 11", q_addr.size());
    else passed++;
    checks++; if (done_off !== 5) $display("FAIL b2b_first_done_off: got %0d expected 5", done_off); else passed++;
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_n3p: got %0b expected 1", cmd_ready); else passed++;
    tick();
    cmd_valid = 1'b0;
    checks++; if ({busy, cmd_ready} !== 2'b10) $display("FAIL b2b_second_accept: got %b expected 10", {busy, cmd_ready}); else passed++;
    collect(50);
    checks++;
    if (q_addr.size() != 2 || {q_addr[0], q_addr[1], q_data[0], q_data[1]} !== {19'd645, 19'd646, 8'h22, 8'h22})
      $display("FAIL b2b_second_pixels: got %0d writes expected addr 645,646 colour 22", q_addr.size());
    else passed++;
    checks++; if (done_off !== 4) $display("FAIL b2b_second_done_off: got %0d expected 4", done_off); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int stray;
    issue(10'd0, 10'd2, 10'd16, 10'd1, 8'h33, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({wr_en, wr_addr} !== {1'b1, 19'(1280 + k)})
        $display("FAIL midreset_pixel%0d: got en %0b addr %0d expected en 1 addr %0d", k, wr_en, wr_addr, 1280 + k);
      else passed++;
      if (k < 2) tick();
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if ({wr_en, done, cmd_ready, busy} !== 4'b0010) $display("FAIL midreset_flags: got %b expected 0010", {wr_en, done, cmd_ready, busy}); else passed++;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wr_en || done) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL midreset_quiet: got %0d active cycles expected 0", stray); else passed++;
    issue(10'd1, 10'd0, 10'd2, 10'd2, 8'h44, 1'b0);
    collect(50);
    checks++;
    if (q_addr.size() != 4 || {q_addr[0], q_addr[1], q_addr[2], q_addr[3]} !== {19'd1, 19'd2, 19'd641, 19'd642} ||
        {q_data[0], q_data[3]} !== {8'h44, 8'h44})
      $display("FAIL midreset_fresh_pixels: got %0d writes expected addr 1,2,641,642 colour 44", q_addr.size());
    else passed++;
    checks++; if (done_off !== 6) $display("FAIL midreset_fresh_done_off: got %0d expected 6", done_off); else passed++;
    tick();
  endtask

  // Clear on the 640x32 instance: 20480 contiguous writes, done at N+2+P.
  task automatic test_clear();
    int off, nwr, err, first, dn;
    cmd_x = 10'd700; cmd_y = 10'd5; cmd_w = 10'd0; cmd_h = 10'd0;
    cmd_color = 8'h00; cmd_clear = 1'b1;
    s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
    off = 1; nwr = 0; err = 0; first = -1; dn = -1;
    while (off <= 25000) begin
      if (s_wr_en) begin
        if (s_wr_addr !== 19'(nwr) || s_wr_data !== 8'h00) err++;
        if (first < 0) first = off;
        nwr++;
      end
      if (s_done) begin
        dn = off;
        break;
      end
      tick();
      off++;
    end
    checks++; if (nwr !== 20480) $display("FAIL clear_count: got %0d expected 20480", nwr); else passed++;
    checks++; if (err !== 0) $display("FAIL clear_sequence: got %0d bad writes expected 0", err); else passed++;
    checks++; if (first !== 2) $display("FAIL clear_first_off: got %0d expected 2", first); else passed++;
    checks++; if (dn !== 20482) $display("FAIL clear_done_off: got %0d expected 20482", dn); else passed++;
    tick();
    checks++; if (s_cmd_ready !== 1'b1) $display("FAIL clear_ready: got %0b expected 1", s_cmd_ready); else passed++;
    cmd_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rect();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_mid_fill();
    test_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_painter.md
# frame_painter

Write-side engine for the 640x480, 8-bit-per-pixel frame buffer: drives its write address, write data and write enable, while `frame_displayer` reads the buffer out to VGA. It accepts one rectangle-fill command at a time, decoded from the software `to_hw` ports, and writes one pixel per clock in row-major order. Rectangles are clipped to the screen. A full-screen clear mode is also provided.

## Interface
Parameters:
- `H_RES`, 640, visible width in pixels
- `V_RES`, 480, visible height in pixels
- `ADDR_W`, 19, frame buffer address width
- `PIX_W`, 8, pixel colour width

Ports:
- `Clk`  in  1  system clock (CLOCK_50)
- `Reset`  in  1  reset; synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block idle, command accepted when `cmd_valid & cmd_ready`
- `cmd_x`, `cmd_y`  in  10 each  top-left corner
- `cmd_w`, `cmd_h`  in  10 each  width and height in pixels
- `cmd_color`  in  `PIX_W`  fill colour
- `cmd_clear`  in  1  fill whole screen; coordinates ignored
- `wr_addr`  out  `ADDR_W`  frame buffer write address, equal to y*H_RES + x
- `wr_data`  out  `PIX_W`  frame buffer write data
- `wr_en`  out  1  frame buffer write enable
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, SETUP, FILL, DONE.
  - `cmd_ready = (state == IDLE)`.
  - `busy = (state != IDLE)`.
- **IDLE:** on the accept handshake, latch `cmd_*` and go to SETUP. The command fields are sampled only on the accept edge.
- **SETUP:** compute clipped bounds with 11-bit sums, no wrap:
  - `x_end = min(cmd_x + cmd_w, H_RES)`
  - `y_end = min(cmd_y + cmd_h, V_RES)`
  - `cmd_clear` forces x0 = y0 = 0, `x_end = H_RES`, `y_end = V_RES`.
  - Row base is `y0*640 = (y0<<9) + (y0<<7)`, computed with shift-add only; no multiplier is allowed.
  - The region is empty if `cmd_x >= H_RES`, `cmd_y >= V_RES`, `cmd_w == 0` or `cmd_h == 0`. Empty goes to DONE, otherwise to FILL.
- **FILL:** each cycle: `wr_en = 1`, `wr_addr = row_base + x`, `wr_data = colour`.
  - When `x == x_end-1`: set x to x0, add H_RES to row_base, increment y.
  - After the last pixel (`x == x_end-1` and `y == y_end-1`), go to DONE.
- **DONE:** `done = 1` for one cycle, `wr_en = 0`, then go to IDLE.
- `cmd_valid` is ignored outside IDLE and while `Reset` is high. A held `cmd_valid` is accepted on the first IDLE cycle.

## Timing
- Reset values, effective on the edge where `Reset` = 1:
  - state IDLE
  - `wr_en`, `wr_addr`, `wr_data`, `done`, `busy`: 0
  - `cmd_ready`: 1
- Reset mid-FILL: `wr_en` is 0 from the next cycle, no `done` pulse is issued, and the partial fill is abandoned.
- Let the accept edge end cycle N and P = number of clipped pixels.
  - N+1: SETUP.
  - N+2 .. N+1+P: `wr_en` high, one pixel per cycle, no gaps.
  - N+2+P: `done` high.
  - N+3+P: `cmd_ready` high.
- Empty command: `done` at N+2, no `wr_en`.
- Outputs are registered. The frame buffer samples `wr_*` on the same `Clk` edge that follows.
- Maximum P = 307200 (full clear).

## Structure
- Shared package `frame_pkg` holds `H_RES`, `V_RES`, `FB_ADDR_W`, `FB_PIX_W` and the `painter_state_t` enum. `frame_displayer` imports the same constants.
- One sub-module, `painter_addr_gen`:
  - Holds the x, y and row_base counters.
  - Inputs: `load` (x0, y0, x_end, y_end), `step`.
  - Outputs: `addr`, `last`.
- The top-level `frame_painter` holds the FSM and the output registers.

## Test plan
- Rect x=10, y=20, w=4, h=2, colour 0x5A:
  - `wr_addr` 12810..12813 then 13450..13453, all with `wr_data` 0x5A.
  - 8 `wr_en` cycles, `done` at N+10.
- Clip x=638, y=479, w=5, h=5: exactly 2 writes, at 307198 and 307199, then `done`.
- Clear with colour 0x00: 307200 writes, addresses 0..307199 contiguous, `done` at N+307202.
- `w=0`, or `x=640`: no `wr_en`, `done` at N+2, `cmd_ready` back at N+3.
- `cmd_valid` held high with two different commands queued: the second is accepted exactly at N+3+P. A `cmd_*` change during FILL has no effect on the first command.
- `Reset` pulse after 3 pixels of a 16-pixel fill: `wr_en` is 0 from the next cycle, no `done`, `cmd_ready` = 1, and a fresh command then completes normally.
